// File: rtl/ula_pkg.sv
// Shared ALU definitions: opcode encoding, flag bit positions, flag record
// and the sticky-flag accumulation rule used by the pipeline top.
package ula_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_XOR = 3'b011,
    OP_SLL = 3'b100,
    OP_SRL = 3'b101,
    OP_SUB = 3'b110,
    OP_SLT = 3'b111
  } opcode_t;

  localparam int CARRY    = 3;
  localparam int NEGATIVO = 2;
  localparam int OVERFLOW = 1;
  localparam int ZERO     = 0;

  // Field order matches the {Carry,Negativo,Overflow,Zero} vector layout.
  typedef struct packed {
    logic carry;
    logic negativo;
    logic overflow;
    logic zero;
  } flags_t;

  // Next value of the sticky flag vector. A clear that coincides with a
  // delivery keeps exactly the delivered flags rather than discarding them.
  function automatic logic [3:0] acumulaFlags(input logic [3:0] acum,
                                               input flags_t     novas,
                                               input logic       entrega,
                                               input logic       limpa);
    logic [3:0] vetor;
    logic [3:0] proximo;
    vetor           = 4'b0000;
    vetor[CARRY]    = novas.carry;
    vetor[NEGATIVO] = novas.negativo;
    vetor[OVERFLOW] = novas.overflow;
    vetor[ZERO]     = novas.zero;
    if (limpa && entrega) begin
      proximo = vetor;
    end else if (limpa) begin
      proximo = 4'b0000;
    end else if (entrega) begin
      proximo = acum | vetor;
    end else begin
      proximo = acum;
    end
    return proximo;
  endfunction

endpackage

// File: rtl/ula_nucleo.sv
// Combinational ALU core: one opcode and two operands in, result and the
// four status flags out. Holds no state; the pipeline top registers it.
module ula_nucleo
  import ula_pkg::*;
#(
  parameter int LARGURA = 32
) (
  input  logic [2:0]         F,
  input  logic [LARGURA-1:0] A,
  input  logic [LARGURA-1:0] B,
  output logic [LARGURA-1:0] Resultado,
  output flags_t             Flags
);

  localparam int SHW = $clog2(LARGURA);
  localparam int MSB = LARGURA - 1;

  opcode_t            op_s;
  logic               ehSub_s;
  logic [LARGURA-1:0] operandoB_s;
  logic [LARGURA:0]   soma_s;
  logic               somaOvf_s;
  logic [SHW-1:0]     quantia_s;
  logic [LARGURA:0]   deslEsq_s;
  logic [LARGURA:0]   deslDir_s;
  logic               menor_s;
  logic [LARGURA-1:0] res_s;
  logic               carry_s;
  logic               ovf_s;

  assign op_s        = opcode_t'(F);
  assign ehSub_s     = (op_s == OP_SUB);
  // Subtraction reuses the adder as A + ~B + 1, so Carry=1 means no borrow.
  assign operandoB_s = ehSub_s ? ~B : B;
  assign soma_s      = {1'b0, A} + {1'b0, operandoB_s} + {{LARGURA{1'b0}}, ehSub_s};
  assign somaOvf_s   = (A[MSB] == operandoB_s[MSB]) && (soma_s[MSB] != A[MSB]);

  // Only the low log2(LARGURA) bits of B count as shift amount. The extra
  // guard bit on each side catches the last bit shifted out, and stays 0
  // for a zero amount.
  assign quantia_s = B[SHW-1:0];
  assign deslEsq_s = {1'b0, A} << quantia_s;
  assign deslDir_s = {A, 1'b0} >> quantia_s;
  assign menor_s   = ($signed(A) < $signed(B));

  // Select the result and the opcode-dependent Carry/Overflow.
  always_comb begin
    res_s   = {LARGURA{1'b0}};
    carry_s = 1'b0;
    ovf_s   = 1'b0;
    case (op_s)
      OP_AND: res_s = A & B;
      OP_OR:  res_s = A | B;
      OP_XOR: res_s = A ^ B;
      OP_ADD, OP_SUB: begin
        res_s   = soma_s[LARGURA-1:0];
        carry_s = soma_s[LARGURA];
        ovf_s   = somaOvf_s;
      end
      OP_SLL: begin
        res_s   = deslEsq_s[LARGURA-1:0];
        carry_s = deslEsq_s[LARGURA];
      end
      OP_SRL: begin
        res_s   = deslDir_s[LARGURA:1];
        carry_s = deslDir_s[0];
      end
      OP_SLT: res_s = {{(LARGURA-1){1'b0}}, menor_s};
      default: begin
        res_s   = {LARGURA{1'b0}};
        carry_s = 1'b0;
        ovf_s   = 1'b0;
      end
    endcase
  end

  assign Resultado      = res_s;
  assign Flags.carry    = carry_s;
  assign Flags.negativo = res_s[MSB];
  assign Flags.overflow = ovf_s;
  assign Flags.zero     = (res_s == {LARGURA{1'b0}});

endmodule

// File: rtl/ula_n_pipe.sv
// Two-stage elastic ALU pipeline. Stage 1 captures the operand triple,
// stage 2 captures the computed result and flags. Each stage accepts when
// empty or when its contents move on this cycle, so one op per cycle flows
// with the consumer ready and up to two ops park during a stall.
module ula_n_pipe
  import ula_pkg::*;
#(
  parameter int LARGURA = 32
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic               Entrada_valida,
  output logic               Entrada_pronta,
  input  logic [2:0]         F,
  input  logic [LARGURA-1:0] A,
  input  logic [LARGURA-1:0] B,
  output logic               Saida_valida,
  input  logic               Saida_pronta,
  output logic [LARGURA-1:0] Resultado,
  output logic               Zero,
  output logic               Overflow,
  output logic               Negativo,
  output logic               Carry,
  output logic [3:0]         Flags_acum,
  input  logic               Limpa_flags
);

  logic               est1Valido_r;
  logic [2:0]         est1F_r;
  logic [LARGURA-1:0] est1A_r;
  logic [LARGURA-1:0] est1B_r;
  logic               est2Valido_r;
  logic [LARGURA-1:0] est2Res_r;
  flags_t             est2Flags_r;
  logic [3:0]         acum_r;

  logic               est1Pronto_s;
  logic               est2Pronto_s;
  logic               transfSaida_s;
  logic [LARGURA-1:0] nucleoRes_s;
  flags_t             nucleoFlags_s;

  assign est2Pronto_s  = !est2Valido_r || Saida_pronta;
  assign est1Pronto_s  = !est1Valido_r || est2Pronto_s;
  assign transfSaida_s = est2Valido_r && Saida_pronta;

  ula_nucleo #(
    .LARGURA (LARGURA)
  ) u_nucleo (
    .F         (est1F_r),
    .A         (est1A_r),
    .B         (est1B_r),
    .Resultado (nucleoRes_s),
    .Flags     (nucleoFlags_s)
  );

  // Stage-1 occupancy: refills (or empties) only when the stage can accept.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      est1Valido_r <= 1'b0;
    end else if (est1Pronto_s) begin
      est1Valido_r <= Entrada_valida;
    end else begin
      est1Valido_r <= est1Valido_r;
    end
  end

  // Stage-1 operands: loaded only on an input transfer, so idle cycles leave them untouched.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      est1F_r <= 3'b000;
      est1A_r <= {LARGURA{1'b0}};
      est1B_r <= {LARGURA{1'b0}};
    end else if (est1Pronto_s && Entrada_valida) begin
      est1F_r <= F;
      est1A_r <= A;
      est1B_r <= B;
    end else begin
      est1F_r <= est1F_r;
      est1A_r <= est1A_r;
      est1B_r <= est1B_r;
    end
  end

  // Stage-2 occupancy: takes stage 1 whenever the consumer is not stalling it.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      est2Valido_r <= 1'b0;
    end else if (est2Pronto_s) begin
      est2Valido_r <= est1Valido_r;
    end else begin
      est2Valido_r <= est2Valido_r;
    end
  end

  // Stage-2 result and flags: frozen while a presented result waits for the consumer.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      est2Res_r   <= {LARGURA{1'b0}};
      est2Flags_r <= 4'b0000;
    end else if (est2Pronto_s && est1Valido_r) begin
      est2Res_r   <= nucleoRes_s;
      est2Flags_r <= nucleoFlags_s;
    end else begin
      est2Res_r   <= est2Res_r;
      est2Flags_r <= est2Flags_r;
    end
  end

  // Sticky flags: OR in each delivered result's flags, with synchronous clear.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      acum_r <= 4'b0000;
    end else begin
      acum_r <= acumulaFlags(acum_r, est2Flags_r, transfSaida_s, Limpa_flags);
    end
  end

  assign Entrada_pronta = est1Pronto_s;
  assign Saida_valida   = est2Valido_r;
  assign Resultado      = est2Res_r;
  assign Carry          = est2Flags_r.carry;
  assign Negativo       = est2Flags_r.negativo;
  assign Overflow       = est2Flags_r.overflow;
  assign Zero           = est2Flags_r.zero;
  assign Flags_acum     = acum_r;

endmodule

// File: tb/tb_ula_n_pipe.sv
// Bench for ula_n_pipe: directed corner cases on a 32-bit and an 8-bit
// instance plus handshake streams scored against an arithmetic model.
module tb_ula_n_pipe;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic Reset_n;

  logic        ev, ep, sv, sp, z, o, n, c, lf;
  logic [2:0]  f;
  logic [31:0] a, b, res;
  logic [3:0]  acum;

  logic        ev8, ep8, sv8, sp8, z8, o8, n8, c8, lf8;
  logic [2:0]  f8;
  logic [7:0]  a8, b8, res8;
  logic [3:0]  acum8;

  int errors = 0;
  int checks = 0;
  logic [3:0] modelAcum;

  ula_n_pipe #(.LARGURA(32)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Entrada_valida(ev), .Entrada_pronta(ep),
    .F(f), .A(a), .B(b), .Saida_valida(sv), .Saida_pronta(sp), .Resultado(res),
    .Zero(z), .Overflow(o), .Negativo(n), .Carry(c), .Flags_acum(acum),
    .Limpa_flags(lf));

  ula_n_pipe #(.LARGURA(8)) dut8 (
    .Clock(Clock), .Reset_n(Reset_n), .Entrada_valida(ev8), .Entrada_pronta(ep8),
    .F(f8), .A(a8), .B(b8), .Saida_valida(sv8), .Saida_pronta(sp8), .Resultado(res8),
    .Zero(z8), .Overflow(o8), .Negativo(n8), .Carry(c8), .Flags_acum(acum8),
    .Limpa_flags(lf8));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural ALU: plain integer arithmetic for a width w (8..32).
  function automatic void refOp(input int w, input logic [2:0] op,
                                input longint unsigned ai, input longint unsigned bi,
                                output longint unsigned r, output logic [3:0] fl);
    longint unsigned mask, av, bv, full;
    longint sa, sb, sr, maxS, minS;
    int amt;
    logic cy, ov;
    mask = (64'd1 << w) - 64'd1;
    av = ai & mask;
    bv = bi & mask;
    maxS = (64'sd1 <<< (w - 1)) - 64'sd1;
    minS = -maxS - 64'sd1;
    sa = av[w-1] ? (longint'(av) - longint'(mask) - 64'sd1) : longint'(av);
    sb = bv[w-1] ? (longint'(bv) - longint'(mask) - 64'sd1) : longint'(bv);
    amt = int'(bv[5:0]) & (w - 1);
    cy = 1'b0;
    ov = 1'b0;
    r = 64'd0;
    case (op)
      3'd0: r = av & bv;
      3'd1: r = av | bv;
      3'd3: r = av ^ bv;
      3'd2: begin
        full = av + bv;
        r = full & mask;
        cy = (full > mask);
        sr = sa + sb;
        ov = (sr > maxS) || (sr < minS);
      end
      3'd6: begin
        r = (av - bv) & mask;
        cy = (av >= bv);
        sr = sa - sb;
        ov = (sr > maxS) || (sr < minS);
      end
      3'd4: begin
        r = (av << amt) & mask;
        cy = (amt != 0) && (((av >> (w - amt)) & 64'd1) != 64'd0);
      end
      3'd5: begin
        r = av >> amt;
        cy = (amt != 0) && (((av >> (amt - 1)) & 64'd1) != 64'd0);
      end
      default: r = (sa < sb) ? 64'd1 : 64'd0;
    endcase
    fl = {cy, r[w-1], ov, (r == 64'd0)};
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // One op on the 32-bit instance with the consumer ready; returns at the
  // cycle its result is presented (two cycles after the input transfer).
  task automatic issue32(input logic [2:0] fo, input logic [31:0] ao, input logic [31:0] bo);
    @(negedge Clock);
    ev = 1'b1; f = fo; a = ao; b = bo; sp = 1'b1;
    #1 chk("aceita", 64'(ep), 64'd1);
    @(negedge Clock);
    ev = 1'b0; f = 3'($urandom); a = $urandom; b = $urandom;
    chk("latencia1", 64'(sv), 64'd0);
    @(negedge Clock);
    chk("latencia2", 64'(sv), 64'd1);
  endtask

  task automatic issue8(input logic [2:0] fo, input logic [7:0] ao, input logic [7:0] bo);
    @(negedge Clock);
    ev8 = 1'b1; f8 = fo; a8 = ao; b8 = bo;
    @(negedge Clock);
    ev8 = 1'b0; f8 = 3'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
    chk("latencia8_1", 64'(sv8), 64'd0);
    @(negedge Clock);
    chk("latencia8_2", 64'(sv8), 64'd1);
  endtask

  // Streams nOps through the 32-bit instance. directed=1: back-to-back ops
  // with the consumer stalled on cycles 3..6; directed=0: random handshakes.
  task automatic runStream(input int nOps, input bit directed);
    logic [31:0] qRes[$];
    logic [3:0]  qFl[$];
    int issued = 0;
    int cycle = 0;
    bit stalled = 1'b0;
    bit sawFull = 1'b0;
    bit havePending = 1'b0;
    logic [31:0] heldRes = 32'd0;
    logic [3:0]  heldFl = 4'd0;
    logic [2:0]  pf = 3'd0;
    logic [31:0] pa = 32'd0, pb = 32'd0;
    logic [31:0] er;
    logic [3:0]  efl;
    longint unsigned r64;
    logic [3:0] fl4;
    while ((issued < nOps || qRes.size() > 0) && cycle < 3000) begin
      @(negedge Clock);
      chk("flags_acum", 64'(acum), 64'(modelAcum));
      if (stalled) begin
        chk("estavel_res", 64'(res), 64'(heldRes));
        chk("estavel_flags", 64'({c, n, o, z}), 64'(heldFl));
        chk("estavel_valida", 64'(sv), 64'd1);
      end
      sp = directed ? !(cycle >= 3 && cycle <= 6) : ($urandom_range(0, 3) != 0);
      lf = directed ? 1'b0 : ($urandom_range(0, 15) == 0);
      if (issued < nOps && (directed || $urandom_range(0, 4) != 0)) begin
        if (!havePending) begin
          if (directed) begin
            pf = 3'(issued % 8);
            pa = 32'h1234_5679 * 32'(issued + 1);
            pb = 32'h0F0F_0F0F ^ 32'(issued);
          end else begin
            pf = 3'($urandom_range(0, 7));
            pa = pick32();
            pb = pick32();
          end
          havePending = 1'b1;
        end
        ev = 1'b1; f = pf; a = pa; b = pb;
      end else begin
        ev = 1'b0; f = 3'($urandom); a = $urandom; b = $urandom;
      end
      #1;
      chk("entrada_pronta", 64'(ep), 64'(!(qRes.size() == 2 && !sp)));
      if (!ep) sawFull = 1'b1;
      if (sv && sp) begin
        if (qRes.size() == 0) begin
          chk("saida_sem_pendente", 64'(sv), 64'd0);
        end else begin
          er = qRes.pop_front();
          efl = qFl.pop_front();
          chk("resultado", 64'(res), 64'(er));
          chk("flags", 64'({c, n, o, z}), 64'(efl));
          modelAcum = (lf ? 4'b0000 : modelAcum) | efl;
        end
      end else if (lf) begin
        modelAcum = 4'b0000;
      end
      if (ev && ep) begin
        refOp(32, f, 64'(a), 64'(b), r64, fl4);
        qRes.push_back(32'(r64));
        qFl.push_back(fl4);
        issued++;
        havePending = 1'b0;
        chk("em_voo", 64'(qRes.size() <= 2), 64'd1);
      end
      stalled = sv && !sp;
      heldRes = res;
      heldFl = {c, n, o, z};
      cycle++;
    end
    chk("ops_pendentes", 64'(qRes.size()), 64'd0);
    chk("ops_emitidas", 64'(issued), 64'(nOps));
    if (directed) chk("pronta_baixou", 64'(sawFull), 64'd1);
  endtask

  initial begin
    longint unsigned r64;
    logic [3:0] fl4;
    logic [7:0] ra, rb;
    logic [2:0] rf;

    Reset_n = 1'b0;
    ev = 1'b0; f = 3'd0; a = 32'd0; b = 32'd0; sp = 1'b1; lf = 1'b0;
    ev8 = 1'b0; f8 = 3'd0; a8 = 8'd0; b8 = 8'd0; sp8 = 1'b1; lf8 = 1'b0;
    modelAcum = 4'b0000;
    repeat (2) @(negedge Clock);
    chk("rst_valida", 64'(sv), 64'd0);
    chk("rst_res", 64'(res), 64'd0);
    chk("rst_flags", 64'({c, n, o, z}), 64'd0);
    chk("rst_acum", 64'(acum), 64'd0);
    chk("rst_valida8", 64'(sv8), 64'd0);
    Reset_n = 1'b1;
    #1 chk("pronta_pos_rst", 64'(ep), 64'd1);

    // ADD overflow into the sign bit
    issue32(3'b010, 32'h7FFF_FFFF, 32'h0000_0001);
    chk("add_res", 64'(res), 64'h8000_0000);
    chk("add_flags", 64'({c, n, o, z}), 64'b0110);
    @(negedge Clock);
    chk("add_acum", 64'(acum), 64'b0110);
    chk("add_entregue", 64'(sv), 64'd0);

    // SUB equal operands: zero, no borrow
    issue32(3'b110, 32'h5, 32'h5);
    chk("sub_res", 64'(res), 64'd0);
    chk("sub_flags", 64'({c, n, o, z}), 64'b1001);
    issue32(3'b111, 32'hFFFF_FFFF, 32'h1);
    chk("slt_res", 64'(res), 64'd1);
    chk("slt_flags", 64'({c, n, o, z}), 64'b0000);
    chk("acum_1111", 64'(acum), 64'b1111);

    // Clear, then ADD with carry followed by AND giving zero
    @(negedge Clock);
    lf = 1'b1;
    @(negedge Clock);
    lf = 1'b0;
    chk("acum_limpo", 64'(acum), 64'd0);
    issue32(3'b010, 32'hFFFF_FFFF, 32'h2);
    chk("addc_res", 64'(res), 64'd1);
    chk("addc_flags", 64'({c, n, o, z}), 64'b1000);
    issue32(3'b000, 32'h0000_00F0, 32'h0000_000F);
    chk("and_flags", 64'({c, n, o, z}), 64'b0001);
    @(negedge Clock);
    chk("acum_1001", 64'(acum), 64'b1001);

    // Clear coinciding with a delivery keeps that delivery's flags
    issue32(3'b011, 32'h0, 32'h0);
    lf = 1'b1;
    @(negedge Clock);
    lf = 1'b0;
    chk("acum_limpa_entrega", 64'(acum), 64'b0001);

    // Reset with two ops in flight
    @(negedge Clock);
    sp = 1'b0; ev = 1'b1; f = 3'b010; a = 32'd1; b = 32'd1;
    @(negedge Clock);
    f = 3'b001; a = 32'd3; b = 32'd4;
    #1 chk("pronta_um_em_voo", 64'(ep), 64'd1);
    @(negedge Clock);
    ev = 1'b0;
    #1;
    chk("pronta_cheio", 64'(ep), 64'd0);
    chk("valida_cheio", 64'(sv), 64'd1);
    #1 Reset_n = 1'b0;
    #1;
    chk("rst_voo_valida", 64'(sv), 64'd0);
    chk("rst_voo_acum", 64'(acum), 64'd0);
    chk("rst_voo_res", 64'(res), 64'd0);
    @(negedge Clock);
    Reset_n = 1'b1; sp = 1'b1;
    #1 chk("rst_voo_pronta", 64'(ep), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      chk("sem_resto", 64'(sv), 64'd0);
    end
    modelAcum = 4'b0000;

    runStream(8, 1'b1);
    runStream(150, 1'b0);

    // 8-bit instance: shift corners, then random ops
    issue8(3'b100, 8'h81, 8'h01);
    chk("sll8_res", 64'(res8), 64'h02);
    chk("sll8_flags", 64'({c8, n8, o8, z8}), 64'b1000);
    issue8(3'b101, 8'h81, 8'h08);
    chk("srl8_res", 64'(res8), 64'h81);
    chk("srl8_flags", 64'({c8, n8, o8, z8}), 64'b0100);
    issue8(3'b101, 8'h81, 8'h01);
    chk("srl8b_res", 64'(res8), 64'h40);
    chk("srl8b_flags", 64'({c8, n8, o8, z8}), 64'b1000);
    for (int i = 0; i < 24; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = 8'($urandom);
      rb = 8'($urandom);
      issue8(rf, ra, rb);
      refOp(8, rf, 64'(ra), 64'(rb), r64, fl4);
      chk("rnd8_res", 64'(res8), r64);
      chk("rnd8_flags", 64'({c8, n8, o8, z8}), 64'(fl4));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
